// File: rtl/imm_extend_pipe.sv
// ============================================================================
//  Module   : imm_extend_pipe
//  Brief    : Registered RV32/RV64 + RVC immediate generator behind a
//             valid/ready handshake with a one-entry skid buffer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module imm_extend_pipe #(
    parameter int XLEN   = 32,
    parameter int RVC_EN = 1,
    parameter int TAG_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [4:0]       i_immSrc,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_immExt,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    logic [63:0]      imm_full;
    logic             dec_illegal;
    logic [XLEN-1:0]  dec_imm;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    logic             accept;
    logic             main_free;
    logic             unused_bits;

    // Every format is built at 64 bits and truncated, so sign extension
    // needs no XLEN-dependent replication counts.
    always_comb begin
        imm_full    = 64'd0;
        dec_illegal = 1'b0;
        case (i_immSrc)
            5'd0, 5'd1, 5'd6: imm_full = {{52{i_inst[31]}}, i_inst[31:20]};
            5'd2: imm_full = (XLEN == 64) ? {58'd0, i_inst[25:20]}
                                          : {59'd0, i_inst[24:20]};
            5'd3:  imm_full = {{52{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            5'd4:  imm_full = {{32{i_inst[31]}}, i_inst[31:12], 12'd0};
            5'd5:  imm_full = {{51{i_inst[31]}}, i_inst[31], i_inst[7],
                               i_inst[30:25], i_inst[11:8], 1'b0};
            5'd7:  imm_full = {{43{i_inst[31]}}, i_inst[31], i_inst[19:12],
                               i_inst[20], i_inst[30:21], 1'b0};
            5'd8:  imm_full = {{58{i_inst[12]}}, i_inst[12], i_inst[6:2]};
            5'd9:  imm_full = {{46{i_inst[12]}}, i_inst[12], i_inst[6:2], 12'd0};
            5'd10: imm_full = {{54{i_inst[12]}}, i_inst[12], i_inst[4:3],
                               i_inst[5], i_inst[2], i_inst[6], 4'd0};
            5'd11: imm_full = {54'd0, i_inst[10:7], i_inst[12:11],
                               i_inst[5], i_inst[6], 2'd0};
            5'd12: imm_full = {57'd0, i_inst[5], i_inst[12:10], i_inst[6], 2'd0};
            5'd13: imm_full = {56'd0, i_inst[3:2], i_inst[12], i_inst[6:4], 2'd0};
            5'd14: imm_full = {56'd0, i_inst[8:7], i_inst[12:9], 2'd0};
            5'd15: imm_full = {{52{i_inst[12]}}, i_inst[12], i_inst[8],
                               i_inst[10:9], i_inst[6], i_inst[7], i_inst[2],
                               i_inst[11], i_inst[5:3], 1'b0};
            5'd16: imm_full = {{55{i_inst[12]}}, i_inst[12], i_inst[6:5],
                               i_inst[2], i_inst[11:10], i_inst[4:3], 1'b0};
            default: dec_illegal = 1'b1;
        endcase
        if (RVC_EN == 0 && i_immSrc >= 5'd8 && i_immSrc <= 5'd16) begin
            dec_illegal = 1'b1;
        end
        if (dec_illegal) begin
            imm_full = 64'd0;
        end
    end

    assign dec_imm     = imm_full[XLEN-1:0];
    assign unused_bits = ^{i_inst[1:0], imm_full};

    assign accept    = i_valid && o_ready;
    assign main_free = !o_valid || i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_ready      <= 1'b1;
            o_immExt     <= '0;
            o_illegal    <= 1'b0;
            o_tag        <= '0;
            skid_valid   <= 1'b0;
            skid_imm     <= '0;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else if (i_flush) begin
            o_valid    <= 1'b0;
            skid_valid <= 1'b0;
            o_ready    <= 1'b1;
        end else if (main_free) begin
            if (skid_valid) begin
                o_valid    <= 1'b1;
                o_immExt   <= skid_imm;
                o_illegal  <= skid_illegal;
                o_tag      <= skid_tag;
                skid_valid <= 1'b0;
                o_ready    <= 1'b1;
            end else if (accept) begin
                o_valid   <= 1'b1;
                o_immExt  <= dec_imm;
                o_illegal <= dec_illegal;
                o_tag     <= i_tag;
            end else begin
                o_valid <= 1'b0;
            end
        end else if (accept) begin
            // Main is stalled; park the new entry so upstream sees a clean stop.
            skid_valid   <= 1'b1;
            skid_imm     <= dec_imm;
            skid_illegal <= dec_illegal;
            skid_tag     <= i_tag;
            o_ready      <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
// ============================================================================
//  Module   : tb_imm_extend_pipe
//  Brief    : Scoreboard bench for imm_extend_pipe (XLEN 32/64, RVC on/off).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic [31:0] inst;
    logic [4:0]  src;
    logic [7:0]  tag;

    logic        rdy_a, vld_a, ill_a;
    logic [31:0] imm_a;
    logic [7:0]  tag_a;
    logic        rdy_b, vld_b, ill_b;
    logic [63:0] imm_b;
    logic [7:0]  tag_b;
    logic        rdy_c, vld_c, ill_c;
    logic [31:0] imm_c;
    logic [7:0]  tag_c;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  src;
        logic [7:0]  tag;
    } ent_t;

    ent_t       q[$];
    logic [7:0] delivered[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .RVC_EN(1), .TAG_W(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_a),
        .i_inst(inst), .i_immSrc(src), .i_tag(tag), .i_flush(flush),
        .o_valid(vld_a), .i_ready(out_ready), .o_immExt(imm_a),
        .o_illegal(ill_a), .o_tag(tag_a));

    imm_extend_pipe #(.XLEN(64), .RVC_EN(1), .TAG_W(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_b),
        .i_inst(inst), .i_immSrc(src), .i_tag(tag), .i_flush(flush),
        .o_valid(vld_b), .i_ready(out_ready), .o_immExt(imm_b),
        .o_illegal(ill_b), .o_tag(tag_b));

    imm_extend_pipe #(.XLEN(32), .RVC_EN(0), .TAG_W(8)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(rdy_c),
        .i_inst(inst), .i_immSrc(src), .i_tag(tag), .i_flush(flush),
        .o_valid(vld_c), .i_ready(out_ready), .o_immExt(imm_c),
        .o_illegal(ill_c), .o_tag(tag_c));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Two's-complement interpretation of an n-bit field, by arithmetic.
    function automatic longint sx(input longint v, input int n);
        if (((v >> (n - 1)) & 1) != 0) return v - (longint'(1) << n);
        return v;
    endfunction

    function automatic logic [64:0] ref_imm(input logic [31:0] x, input logic [4:0] s,
                                            input bit x64, input bit rvc);
        longint v = 0;
        bit     ill = 0;
        case (s)
            0, 1, 6: v = sx(longint'(x[31:20]), 12);
            2:  v = x64 ? longint'(x[25:20]) : longint'(x[24:20]);
            3:  v = sx(longint'({x[31:25], x[11:7]}), 12);
            4:  v = sx(longint'(x[31:12]), 20) * 4096;
            5:  v = sx(longint'({x[31], x[7], x[30:25], x[11:8]}), 12) * 2;
            7:  v = sx(longint'({x[31], x[19:12], x[20], x[30:21]}), 20) * 2;
            8:  v = sx(longint'({x[12], x[6:2]}), 6);
            9:  v = sx(longint'({x[12], x[6:2]}), 6) * 4096;
            10: v = sx(longint'({x[12], x[4:3], x[5], x[2], x[6]}), 6) * 16;
            11: v = longint'({x[10:7], x[12:11], x[5], x[6]}) * 4;
            12: v = longint'({x[5], x[12:10], x[6]}) * 4;
            13: v = longint'({x[3:2], x[12], x[6:4]}) * 4;
            14: v = longint'({x[8:7], x[12:9]}) * 4;
            15: v = sx(longint'({x[12], x[8], x[10:9], x[6], x[7], x[2], x[11], x[5:3]}), 11) * 2;
            16: v = sx(longint'({x[12], x[6:5], x[2], x[11:10], x[4:3]}), 8) * 2;
            default: ill = 1;
        endcase
        if (s >= 8 && s <= 16 && !rvc) ill = 1;
        if (ill) v = 0;
        return {ill, 64'(v)};
    endfunction

    task automatic check_outputs();
        logic [64:0] ra, rb, rc;
        logic        ev  = (q.size() > 0);
        logic        er  = (q.size() < 2);
        check("a.valid", 64'(vld_a), 64'(ev));
        check("b.valid", 64'(vld_b), 64'(ev));
        check("c.valid", 64'(vld_c), 64'(ev));
        check("a.ready", 64'(rdy_a), 64'(er));
        check("b.ready", 64'(rdy_b), 64'(er));
        check("c.ready", 64'(rdy_c), 64'(er));
        if (q.size() > 0) begin
            ra = ref_imm(q[0].inst, q[0].src, 1'b0, 1'b1);
            rb = ref_imm(q[0].inst, q[0].src, 1'b1, 1'b1);
            rc = ref_imm(q[0].inst, q[0].src, 1'b0, 1'b0);
            check("a.imm", 64'(imm_a), 64'(ra[31:0]));
            check("a.ill", 64'(ill_a), 64'(ra[64]));
            check("a.tag", 64'(tag_a), 64'(q[0].tag));
            check("b.imm", imm_b, rb[63:0]);
            check("b.ill", 64'(ill_b), 64'(rb[64]));
            check("b.tag", 64'(tag_b), 64'(q[0].tag));
            check("c.imm", 64'(imm_c), 64'(rc[31:0]));
            check("c.ill", 64'(ill_c), 64'(rc[64]));
            check("c.tag", 64'(tag_c), 64'(q[0].tag));
        end
    endtask

    // Called at a negedge: drive one cycle, advance the model, check at next negedge.
    task automatic step(input logic v, input logic [31:0] i, input logic [4:0] s,
                        input logic [7:0] t, input logic rdy, input logic fl);
        logic       acc, drn;
        logic [7:0] dtag;
        ent_t       e;
        in_valid  = v;
        inst      = i;
        src       = s;
        tag       = t;
        out_ready = rdy;
        flush     = fl;
        acc  = v && rdy_a;
        drn  = vld_a && rdy;
        dtag = tag_a;
        e.inst = i;
        e.src  = s;
        e.tag  = t;
        @(posedge clk);
        if (drn) delivered.push_back(dtag);
        if (fl) begin
            q.delete();
        end else begin
            if (drn && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 0; flush = 0; inst = 0; src = 0; tag = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst.valid", 64'(vld_a), 64'd0);
        check("rst.ready", 64'(rdy_a), 64'd1);
        check("rst.imm",   64'(imm_a), 64'd0);
        check("rst.ill",   64'(ill_a), 64'd0);
        check("rst.tag",   64'(tag_a), 64'd0);
        rst = 1'b0;

        step(1, 32'hFFF00093, 5'd0, 8'd10, 1, 0);
        check("i_load_m1", 64'(imm_a), 64'hFFFF_FFFF);
        step(1, 32'hFE000EE3, 5'd5, 8'd11, 1, 0);
        check("b_m4", 64'(imm_a), 64'hFFFF_FFFC);
        step(1, 32'h03F00000, 5'd2, 8'd12, 1, 0);
        check("shamt64", imm_b, 64'h3F);
        check("shamt32", 64'(imm_a), 64'h1F);
        step(1, 32'h000050FD, 5'd8, 8'd13, 1, 0);
        check("c_li_m1", 64'(imm_a), 64'hFFFF_FFFF);
        check("norvc_ill", 64'(ill_c), 64'd1);
        step(1, 32'h00004092, 5'd13, 8'd14, 1, 0);
        check("c_lwsp_4", 64'(imm_a), 64'h4);
        step(1, 32'hFFFFFFFF, 5'd20, 8'd15, 1, 0);
        check("sel20_ill", 64'(ill_a), 64'd1);
        check("sel20_imm", 64'(imm_a), 64'd0);
        step(1, 32'h00004092, 5'd0, 8'd16, 1, 0);
        check("norvc_legal", 64'(ill_c), 64'd0);
        step(0, 0, 0, 0, 1, 0);

        // Backpressure: 1 in main, 2 in skid, 3 held upstream.
        delivered.delete();
        step(1, 32'h00100093, 5'd0, 8'd1, 0, 0);
        step(1, 32'h00200093, 5'd0, 8'd2, 0, 0);
        step(1, 32'h00300093, 5'd0, 8'd3, 0, 0);
        check("bp.main_tag", 64'(tag_a), 64'd1);
        check("bp.ready", 64'(rdy_a), 64'd0);
        step(1, 32'h00300093, 5'd0, 8'd3, 1, 0);
        step(1, 32'h00300093, 5'd0, 8'd3, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        check("bp.count", 64'(delivered.size()), 64'd3);
        if (delivered.size() == 3) begin
            check("bp.order0", 64'(delivered[0]), 64'd1);
            check("bp.order1", 64'(delivered[1]), 64'd2);
            check("bp.order2", 64'(delivered[2]), 64'd3);
        end

        // Flush with both registers full and a simultaneous input.
        step(1, 32'h00500093, 5'd0, 8'd5, 0, 0);
        step(1, 32'h00600093, 5'd0, 8'd6, 0, 0);
        step(1, 32'h00700093, 5'd0, 8'd7, 0, 1);
        check("fl.valid", 64'(vld_a), 64'd0);
        check("fl.ready", 64'(rdy_a), 64'd1);
        step(0, 0, 0, 0, 1, 0);
        check("fl.no_ghost", 64'(vld_a), 64'd0);

        // Asynchronous reset mid-stream.
        step(1, 32'hFFF00093, 5'd0, 8'd8, 0, 0);
        step(1, 32'hFFF00093, 5'd0, 8'd9, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("ar.valid", 64'(vld_a), 64'd0);
        check("ar.imm",   64'(imm_a), 64'd0);
        check("ar.ready", 64'(rdy_a), 64'd1);
        check("ar.tag",   64'(tag_a), 64'd0);
        q.delete();
        in_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 1, 0);
        check("ar.stale", 64'(vld_a), 64'd0);

        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, $urandom,
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16)),
                 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate generator for the decode stage. It extends 32-bit base immediates to XLEN bits and adds the RVC (16-bit compressed) immediate formats. Invalid selects are flagged as illegal. The block sits between instruction fetch/align and the execute-stage operand muxes, behind a valid/ready handshake with a one-entry skid buffer, and carries a sideband tag alongside the result.

## Interface
- XLEN, 32: result width; legal values 32 or 64.
- RVC_EN, 1: 1 enables compressed formats; 0 makes them illegal.
- TAG_W, 8: sideband tag width (PC index / ROB id); passed through untouched.
- i_clk  in  1  sole clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream has an instruction.
- o_ready  out  1  block can accept; registered, equals !skid_valid.
- i_inst  in  32  instruction; RVC formats use i_inst[15:0].
- i_immSrc  in  5  format select (see Operation).
- i_tag  in  TAG_W  sideband.
- i_flush  in  1  synchronous pipeline kill.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts.
- o_immExt  out  XLEN  extended immediate.
- o_illegal  out  1  select was reserved or disabled.
- o_tag  out  TAG_W  tag of o_immExt.

## Operation
- Select codes. "sext" means sign-extend to XLEN; "zext" means zero-extend.
  - 0, 1, 6 (I load / R+i / jalr): sext(inst[31:20]).
  - 2 (shamt): zext(inst[24:20]) at XLEN=32; zext(inst[25:20]) at XLEN=64.
  - 3 (S): sext({inst[31:25],inst[11:7]}).
  - 4 (U): sext({inst[31:12],12'b0}).
  - 5 (B): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 7 (J): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 8 (CI addi/li): sext({inst[12],inst[6:2]}).
  - 9 (CI lui): sext({inst[12],inst[6:2],12'b0}).
  - 10 (addi16sp): sext({inst[12],inst[4:3],inst[5],inst[2],inst[6],4'b0}).
  - 11 (CIW addi4spn): zext({inst[10:7],inst[12:11],inst[5],inst[6],2'b0}).
  - 12 (CL/CS word): zext({inst[5],inst[12:10],inst[6],2'b0}).
  - 13 (lwsp): zext({inst[3:2],inst[12],inst[6:4],2'b0}).
  - 14 (swsp): zext({inst[8:7],inst[12:9],2'b0}).
  - 15 (CJ): sext({inst[12],inst[8],inst[10:9],inst[6],inst[7],inst[2],inst[11],inst[5:3],1'b0}).
  - 16 (CB): sext({inst[12],inst[6:5],inst[2],inst[11:10],inst[4:3],1'b0}).
  - 17–31, or 8–16 with RVC_EN=0: o_immExt=0, o_illegal=1. Never X.
- Storage: one main register (o_*) and one skid register, each with its own valid bit.
- Accept: i_valid && o_ready. Output handshake: o_valid && i_ready.
- Main register update each edge:
  - If main is empty or being drained: load from skid if skid is valid, else from the accepted input, else clear valid.
  - Otherwise hold.
- Skid register update:
  - Captures an accepted input when main is valid and not draining.
  - Empties when it transfers into main.
- Ordering is strictly FIFO; no drop or duplication under any ready pattern.

## Timing
- Latency: 1 cycle from accept to o_valid with no stall.
- Throughput: 1 per cycle while i_ready=1.
- o_ready falls the cycle after the skid fills; it rises the cycle after the skid drains.
- Reset (async, any time, including mid-transfer): o_valid=0, skid_valid=0, o_ready=1, o_immExt=0, o_illegal=0, o_tag=0. First accept is possible on the first edge after i_rst deasserts.
- i_flush: on the next edge both valids clear and o_ready=1.
  - Flush wins over a simultaneous accept; that input is dropped.
  - Data registers need not clear on flush.
- Full boundary: with main and skid both valid and i_ready=0, the block accepts nothing. If i_ready=1 with skid full, the skid moves to main and no new input is accepted that cycle (o_ready is still 0).
- Data registers load only on transfer; o_immExt is stable while o_valid && !i_ready.

## Test plan
- Reset mid-stream: i_rst pulsed asynchronously while o_valid=1 and skid full -> immediately o_valid=0, o_immExt=0, o_ready=1; no stale output after release.
- Base formats, XLEN=32: i_inst=32'hFFF00093, src=0 -> next cycle o_immExt=32'hFFFFFFFF. i_inst=32'hFE000EE3, src=5 -> 32'hFFFFFFFC. XLEN=64, src=2, inst[25:20]=6'h3F -> 64'h3F.
- RVC: i_inst[15:0]=16'h50FD (c.li x1,-1), src=8 -> 32'hFFFFFFFF. 16'h4092 (c.lwsp x1,4(sp)), src=13 -> 32'h4.
- Backpressure: three back-to-back inputs with tags 1, 2, 3 while i_ready=0 -> tag 1 held in main, tag 2 in skid, o_ready=0, tag 3 held upstream. After i_ready=1: tags 1, 2, 3 delivered in order, each exactly once.
- Flush: both registers full, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1; the flushed-cycle input never appears.
- Illegal: src=5'd20 -> o_illegal=1, o_immExt=0. RVC_EN=0 with src=8 -> o_illegal=1; a legal select the following cycle -> o_illegal=0.
